// File: rtl/rf_dump_reader_if.sv
// rtl/rf_dump_reader_if.sv - dump beat stream between rf_dump_reader and its sink
interface rf_dump_reader_if;
    logic        dump_valid;
    logic        dump_ready;
    logic [5:0]  dump_idx;
    logic [63:0] dump_data;

    modport master (output dump_valid, output dump_idx, output dump_data, input dump_ready);
    modport slave  (input dump_valid, input dump_idx, input dump_data, output dump_ready);
endinterface

// File: rtl/rf_dump_reader.sv
// rtl/rf_dump_reader.sv - register-file dump engine streaming (index, data) beats
// Optional XOR checksum beat (index 32) is compiled in by RF_DUMP_CHECKSUM_EN.
module rf_dump_reader #(
    parameter int unsigned LAST_REG = 31
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [4:0]               rf_addr,
    input  logic [63:0]              rf_data,
    rf_dump_reader_if.master         dump,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
`ifdef RF_DUMP_CHECKSUM_EN
    localparam logic [1:0] S_SUM   = 2'd3;
`endif
    localparam logic [4:0] LAST_IDX = 5'(LAST_REG);

    logic [1:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic [5:0]  didx_q, didx_d;
    logic [63:0] ddata_q, ddata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef RF_DUMP_CHECKSUM_EN
    logic [63:0] acc_q, acc_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        didx_d  = didx_q;
        ddata_d = ddata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
`ifdef RF_DUMP_CHECKSUM_EN
                    acc_d   = 64'd0;
`endif
                end
            end
            // The pre-edge read-port value is captured, so a same-edge write is not seen.
            S_FETCH: begin
                ddata_d = rf_data;
                didx_d  = {1'b0, idx_q};
                valid_d = 1'b1;
                state_d = S_SEND;
`ifdef RF_DUMP_CHECKSUM_EN
                acc_d   = acc_q ^ rf_data;
`endif
            end
            S_SEND: begin
                if (dump.dump_ready) begin
                    valid_d = 1'b0;
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_FETCH;
                    end else begin
`ifdef RF_DUMP_CHECKSUM_EN
                        state_d = S_SUM;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end
                end
            end
`ifdef RF_DUMP_CHECKSUM_EN
            // First SUM cycle loads the checksum beat, mirroring the FETCH/SEND pair.
            S_SUM: begin
                if (!valid_q) begin
                    didx_d  = 6'd32;
                    ddata_d = acc_q;
                    valid_d = 1'b1;
                end else if (dump.dump_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            valid_q <= 1'b0;
            didx_q  <= 6'd0;
            ddata_q <= 64'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
            acc_q   <= 64'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            didx_q  <= didx_d;
            ddata_q <= ddata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RF_DUMP_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign rf_addr         = idx_q;
    assign dump.dump_valid = valid_q;
    assign dump.dump_idx   = didx_q;
    assign dump.dump_data  = ddata_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb/tb_rf_dump_reader.sv - self-checking bench for rf_dump_reader
module tb_rf_dump_reader;

`ifdef RF_DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    typedef struct packed {
        logic [5:0]  idx;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        int pat;
        int stall_at;
        int stall_len;
        int restart_at;
        bit chk_sp;
        int exp_beats;
        int exp_done;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic        ready_a, ready_b;
    logic [4:0]  rf_addr_a, rf_addr_b;
    logic [63:0] rf_data_a, rf_data_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [63:0] rf [32];

    rf_dump_reader_if dif_a ();
    rf_dump_reader_if dif_b ();

    assign dif_a.dump_ready = ready_a;
    assign dif_b.dump_ready = ready_b;
    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];

    rf_dump_reader #(.LAST_REG(31)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .rf_addr(rf_addr_a),
        .rf_data(rf_data_a), .dump(dif_a), .busy(busy_a), .done(done_a));

    rf_dump_reader #(.LAST_REG(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .rf_addr(rf_addr_b),
        .rf_data(rf_data_b), .dump(dif_b), .busy(busy_b), .done(done_b));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    beat_t exp_qa[$];
    beat_t exp_qb[$];
    beat_t e_a, e_b;
    int beats_a, beats_b, done_cnt_a, done_cnt_b;
    int last_hs_a = -1;
    int last_hs_b = -1;
    bit spacing_a = 0;
    bit stall_a = 0;
    logic [5:0]  hold_idx_a;
    logic [63:0] hold_data_a;
    vec_t vecs[5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic preload(input int pat);
        for (int i = 0; i < 32; i++) begin
            case (pat)
                0:       rf[i] = 64'(3 * i);
                1:       rf[i] = 64'd1 << i;
                default: rf[i] = {$urandom(), $urandom()};
            endcase
        end
        rf[31] = 64'd0;
    endtask

    task automatic push_exp(input bit to_b, input int last);
        logic [63:0] sum;
        beat_t b;
        sum = 64'd0;
        for (int i = 0; i <= last; i++) begin
            b.idx  = 6'(i);
            b.data = rf[i];
            sum    = sum ^ rf[i];
            if (to_b) exp_qb.push_back(b); else exp_qa.push_back(b);
        end
`ifdef RF_DUMP_CHECKSUM_EN
        b.idx  = 6'd32;
        b.data = sum;
        if (to_b) exp_qb.push_back(b); else exp_qa.push_back(b);
`endif
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                check("hold_valid", dif_a.dump_valid, 1);
                check("hold_idx", dif_a.dump_idx, hold_idx_a);
                check("hold_data", dif_a.dump_data, hold_data_a);
            end
            if (dif_a.dump_valid && dif_a.dump_ready) begin
                beats_a++;
                if (spacing_a && last_hs_a >= 0) check("beat_spacing", 64'(cyc - last_hs_a), 2);
                last_hs_a = cyc;
                check("beat_expected_a", exp_qa.size() != 0, 1);
                if (exp_qa.size() != 0) begin
                    e_a = exp_qa.pop_front();
                    check("beat_idx_a", dif_a.dump_idx, e_a.idx);
                    check("beat_data_a", dif_a.dump_data, e_a.data);
                end
            end
            if (done_a) begin
                done_cnt_a++;
                check("done_after_last_a", 64'(cyc - last_hs_a), 1);
                check("done_q_empty_a", exp_qa.size(), 0);
                check("busy_at_done_a", busy_a, 0);
            end
            stall_a     = dif_a.dump_valid && !dif_a.dump_ready;
            hold_idx_a  = dif_a.dump_idx;
            hold_data_a = dif_a.dump_data;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (dif_b.dump_valid && dif_b.dump_ready) begin
                beats_b++;
                last_hs_b = cyc;
                check("beat_expected_b", exp_qb.size() != 0, 1);
                if (exp_qb.size() != 0) begin
                    e_b = exp_qb.pop_front();
                    check("beat_idx_b", dif_b.dump_idx, e_b.idx);
                    check("beat_data_b", dif_b.dump_data, e_b.data);
                end
            end
            if (done_b) begin
                done_cnt_b++;
                check("done_after_last_b", 64'(cyc - last_hs_b), 1);
            end
        end
    end

    task automatic run_a(input vec_t v);
        int c0, first_v, stall_left;
        bit restarted;
        preload(v.pat);
        exp_qa.delete();
        push_exp(1'b0, 31);
        beats_a = 0; done_cnt_a = 0; last_hs_a = -1; spacing_a = v.chk_sp;
        first_v = -1; stall_left = v.stall_len; restarted = 0;
        @(posedge clk); #1;
        start_a = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("busy_after_start", busy_a, 1);
        for (int n = 0; n < 400 && done_cnt_a == 0; n++) begin
            @(negedge clk);
            if (first_v < 0 && dif_a.dump_valid) first_v = cyc;
            @(posedge clk); #1;
            start_a = 1'b0;
            ready_a = 1'b1;
            if (stall_left > 0 && dif_a.dump_valid && dif_a.dump_idx == 6'(v.stall_at)) begin
                ready_a = 1'b0;
                stall_left--;
            end
            if (!restarted && dif_a.dump_valid && dif_a.dump_idx == 6'(v.restart_at)) begin
                start_a = 1'b1;
                restarted = 1;
            end
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        check("first_valid_latency", 64'(first_v - c0), 2);
        check("beat_count", beats_a, v.exp_beats);
        check("queue_drained", exp_qa.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", done_cnt_a, v.exp_done);
        check("busy_after_done", busy_a, 0);
    endtask

    initial begin
        vecs[0] = '{pat: 0, stall_at: -1, stall_len: 0, restart_at: -1, chk_sp: 1, exp_beats: 32 + CK, exp_done: 1};
        vecs[1] = '{pat: 0, stall_at:  4, stall_len: 5, restart_at: -1, chk_sp: 0, exp_beats: 32 + CK, exp_done: 1};
        vecs[2] = '{pat: 0, stall_at: -1, stall_len: 0, restart_at: 10, chk_sp: 1, exp_beats: 32 + CK, exp_done: 1};
        vecs[3] = '{pat: 1, stall_at: -1, stall_len: 0, restart_at: -1, chk_sp: 1, exp_beats: 32 + CK, exp_done: 1};
        vecs[4] = '{pat: 2, stall_at: 31, stall_len: 3, restart_at: -1, chk_sp: 0, exp_beats: 32 + CK, exp_done: 1};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        preload(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", dif_a.dump_valid, 0);
        check("rst_idx", dif_a.dump_idx, 0);
        check("rst_data", dif_a.dump_data, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_rf_addr", rf_addr_a, 0);
        rst_n = 1'b1;

        foreach (vecs[r]) run_a(vecs[r]);

        // Reset asserted while beat 7 is on the bus.
        preload(0);
        exp_qa.delete();
        push_exp(1'b0, 31);
        done_cnt_a = 0; spacing_a = 0; last_hs_a = -1;
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int n = 0; n < 100 && !(dif_a.dump_valid && dif_a.dump_idx == 6'd7); n++) begin
            @(posedge clk); #1;
        end
        check("reach_beat7", dif_a.dump_idx, 7);
        rst_n = 1'b0;
        #1;
        check("abort_valid", dif_a.dump_valid, 0);
        check("abort_idx", dif_a.dump_idx, 0);
        check("abort_data", dif_a.dump_data, 0);
        check("abort_busy", busy_a, 0);
        check("abort_rf_addr", rf_addr_a, 0);
        exp_qa.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt_a, 0);
        run_a(vecs[0]);

        // Short dump with a back-to-back start on the done cycle.
        preload(0);
        exp_qb.delete();
        push_exp(1'b1, 3);
        beats_b = 0; done_cnt_b = 0; last_hs_b = -1;
        @(posedge clk); #1;
        start_b = 1'b1;
        begin
            bit again;
            again = 0;
            for (int n = 0; n < 200 && done_cnt_b < 2; n++) begin
                @(posedge clk); #1;
                start_b = 1'b0;
                if (done_b && !again) begin
                    start_b = 1'b1;
                    again = 1;
                    push_exp(1'b1, 3);
                end
            end
        end
        start_b = 1'b0;
        check("short_beats", beats_b, 2 * (4 + CK));
        check("short_done_count", done_cnt_b, 2);
        check("short_queue_drained", exp_qb.size(), 0);
        check("short_busy_idle", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
